// File: rtl/jtag_host_shifter.sv
// jtag_host_shifter: JTAG initiator. Turns parallel DR-scan, IR-scan and
// TAP-reset commands into TCK/TMS/TDI sequences and collects TDO into a
// parallel result. It runs an automatic Test-Logic-Reset sequence after reset.
//
// Ports
//   CLK, nRST     system clock, asynchronous active-low reset
//   start         command request, sampled only while busy=0
//   cmd_op        00 DR scan, 01 IR scan, 10 TAP reset, 11 reserved (rejected)
//   shift_len     scan length 1..MAX_LEN
//   shift_data    TDI bits, bit0 shifted first
//   busy          command (or auto-TLR) in progress
//   done          one-cycle completion pulse
//   err           one-cycle pulse alongside done for a rejected command
//   capture_data  TDO bits, bit0 = first captured, unused upper bits 0
//   TCK/TMS/TDI   TAP drive pins; TDO is the TAP return pin
module jtag_host_shifter #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               start,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   shift_len,
  input  logic [MAX_LEN-1:0] shift_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [MAX_LEN-1:0] capture_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] OP_DR   = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SHIFT,
    S_TRL,
    S_FIN
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic [LEN_W-1:0]   bit_q, bit_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         op_q, op_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               auto_q, auto_d;

  logic               phase_end;
  logic               cmd_bad;

  // TMS value of header period idx for each command type
  function automatic logic hdr_tms(input logic [1:0] op, input logic [LEN_W-1:0] idx);
    case (op)
      OP_IR:   hdr_tms = (idx < LEN_W'(2));
      OP_RST:  hdr_tms = (idx < LEN_W'(5));
      default: hdr_tms = (idx == '0);
    endcase
  endfunction

  // Index of the last header period (TAP reset is header-only)
  function automatic logic [LEN_W-1:0] hdr_last(input logic [1:0] op);
    case (op)
      OP_IR:   hdr_last = LEN_W'(3);
      OP_RST:  hdr_last = LEN_W'(5);
      default: hdr_last = LEN_W'(2);
    endcase
  endfunction

  // Length only matters for scans; a TAP reset ignores shift_len
  assign cmd_bad = (cmd_op == OP_RSVD) ||
                   ((cmd_op != OP_RST) &&
                    ((shift_len == '0) || (32'(shift_len) > MAX_LEN)));

  assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));

  // State register; reset lands in the header of a TAP-reset marked as automatic
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_HDR;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      bit_q   <= '0;
      len_q   <= '0;
      op_q    <= OP_RST;
      data_q  <= '0;
      cap_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      auto_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      auto_q  <= auto_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    bit_d   = bit_q;
    len_d   = len_q;
    op_d    = op_q;
    data_d  = data_q;
    cap_d   = cap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    auto_d  = auto_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cmd_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            // Accept edge is the start of the first TCK low phase
            state_d = S_HDR;
            op_d    = cmd_op;
            len_d   = shift_len;
            data_d  = shift_data;
            busy_d  = 1'b1;
            auto_d  = 1'b0;
            div_d   = '0;
            tck_d   = 1'b0;
            bit_d   = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
            if (cmd_op != OP_RST) begin
              cap_d = '0;
            end
          end
        end
      end

      S_HDR, S_SHIFT, S_TRL: begin
        if (!phase_end) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          tck_d = ~tck_q;
          if (!tck_q) begin
            // Rising TCK: sample TDO during shift periods
            if (state_q == S_SHIFT) begin
              cap_d = cap_q | (MAX_LEN'(TDO) << bit_q);
            end
          end else begin
            // Falling TCK ends a period: set up TMS/TDI for the next one
            bit_d = bit_q + LEN_W'(1);
            case (state_q)
              S_HDR: begin
                if (bit_q == hdr_last(op_q)) begin
                  bit_d = '0;
                  if (op_q == OP_RST) begin
                    state_d = S_FIN;
                    tms_d   = 1'b0;
                  end else begin
                    state_d = S_SHIFT;
                    tms_d   = (len_q == LEN_W'(1));
                    tdi_d   = data_q[0];
                  end
                end else begin
                  tms_d = hdr_tms(op_q, bit_q + LEN_W'(1));
                end
              end
              S_SHIFT: begin
                if (bit_q == len_q - LEN_W'(1)) begin
                  state_d = S_TRL;
                  bit_d   = '0;
                  tms_d   = 1'b1;
                  tdi_d   = 1'b0;
                end else begin
                  data_d = data_q >> 1;
                  tdi_d  = data_d[0];
                  tms_d  = ((bit_q + LEN_W'(2)) == len_q);
                end
              end
              default: begin
                // Trailer: Update (TMS=1) then back to Run-Test/Idle (TMS=0)
                tms_d = 1'b0;
                if (bit_q != '0) begin
                  state_d = S_FIN;
                end
              end
            endcase
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = ~auto_q;
        auto_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign capture_data = cap_q;
  assign TCK          = tck_q;
  assign TMS          = tms_q;
  assign TDI          = tdi_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// tb_jtag_host_shifter: drives jtag_host_shifter (CLK_DIV=2) into a behavioural
// TAP target (5-bit IR capturing 5'b00001, 1-bit bypass DR), plus two idle
// instances with CLK_DIV=1 and CLK_DIV=3 for timing checks.
module tb_jtag_host_shifter;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned LEN_W   = 6;

  localparam logic [3:0] T_TLR = 4'd0,  T_RTI = 4'd1,  T_SEL_DR = 4'd2, T_CAP_DR = 4'd3;
  localparam logic [3:0] T_SH_DR = 4'd4, T_EX1_DR = 4'd5, T_PA_DR = 4'd6, T_EX2_DR = 4'd7;
  localparam logic [3:0] T_UPD_DR = 4'd8, T_SEL_IR = 4'd9, T_CAP_IR = 4'd10, T_SH_IR = 4'd11;
  localparam logic [3:0] T_EX1_IR = 4'd12, T_PA_IR = 4'd13, T_EX2_IR = 4'd14, T_UPD_IR = 4'd15;

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  logic start2 = 1'b0, start1 = 1'b0, start3 = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [LEN_W-1:0] shift_len = '0;
  logic [MAX_LEN-1:0] shift_data = '0;

  logic busy2, done2, err2, tck2, tms2, tdi2;
  logic tdo2 = 1'b0;
  logic [MAX_LEN-1:0] cap2;
  logic busy1, done1, err1, tck1, tms1, tdi1;
  logic [MAX_LEN-1:0] cap1;
  logic busy3, done3, err3, tck3, tms3, tdi3;
  logic [MAX_LEN-1:0] cap3;
  logic tdo_off = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  jtag_host_shifter #(.CLK_DIV(2), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_dut (
    .CLK(CLK), .nRST(nRST), .start(start2), .cmd_op(cmd_op), .shift_len(shift_len),
    .shift_data(shift_data), .busy(busy2), .done(done2), .err(err2), .capture_data(cap2),
    .TCK(tck2), .TMS(tms2), .TDI(tdi2), .TDO(tdo2)
  );

  jtag_host_shifter #(.CLK_DIV(1), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_div1 (
    .CLK(CLK), .nRST(nRST), .start(start1), .cmd_op(cmd_op), .shift_len(shift_len),
    .shift_data(shift_data), .busy(busy1), .done(done1), .err(err1), .capture_data(cap1),
    .TCK(tck1), .TMS(tms1), .TDI(tdi1), .TDO(tdo_off)
  );

  jtag_host_shifter #(.CLK_DIV(3), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_div3 (
    .CLK(CLK), .nRST(nRST), .start(start3), .cmd_op(cmd_op), .shift_len(shift_len),
    .shift_data(shift_data), .busy(busy3), .done(done3), .err(err3), .capture_data(cap3),
    .TCK(tck3), .TMS(tms3), .TDI(tdi3), .TDO(tdo_off)
  );

  // ---------------- behavioural TAP target ----------------
  logic [3:0] tap_st = T_TLR;
  logic [4:0] ir_sr  = 5'h00;
  logic [4:0] ir_reg = 5'h01;
  logic       byp    = 1'b0;
  logic       tms_log[$];

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      T_TLR:    tap_next = m ? T_TLR    : T_RTI;
      T_RTI:    tap_next = m ? T_SEL_DR : T_RTI;
      T_SEL_DR: tap_next = m ? T_SEL_IR : T_CAP_DR;
      T_CAP_DR: tap_next = m ? T_EX1_DR : T_SH_DR;
      T_SH_DR:  tap_next = m ? T_EX1_DR : T_SH_DR;
      T_EX1_DR: tap_next = m ? T_UPD_DR : T_PA_DR;
      T_PA_DR:  tap_next = m ? T_EX2_DR : T_PA_DR;
      T_EX2_DR: tap_next = m ? T_UPD_DR : T_SH_DR;
      T_UPD_DR: tap_next = m ? T_SEL_DR : T_RTI;
      T_SEL_IR: tap_next = m ? T_TLR    : T_CAP_IR;
      T_CAP_IR: tap_next = m ? T_EX1_IR : T_SH_IR;
      T_SH_IR:  tap_next = m ? T_EX1_IR : T_SH_IR;
      T_EX1_IR: tap_next = m ? T_UPD_IR : T_PA_IR;
      T_PA_IR:  tap_next = m ? T_EX2_IR : T_PA_IR;
      T_EX2_IR: tap_next = m ? T_UPD_IR : T_SH_IR;
      default:  tap_next = m ? T_SEL_DR : T_RTI;
    endcase
  endfunction

  always @(posedge tck2) begin
    tms_log.push_back(tms2);
    case (tap_st)
      T_CAP_DR: byp <= 1'b0;
      T_SH_DR:  byp <= tdi2;
      T_CAP_IR: ir_sr <= 5'b00001;
      T_SH_IR:  ir_sr <= {tdi2, ir_sr[4:1]};
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms2);
  end

  always @(negedge tck2) begin
    if (tap_st == T_TLR) ir_reg <= 5'h01;
    else if (tap_st == T_UPD_IR) ir_reg <= ir_sr;
    tdo2 <= (tap_st == T_SH_DR) ? byp : ((tap_st == T_SH_IR) ? ir_sr[0] : 1'b0);
  end

  // ---------------- helpers (stimulus / observation only) ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Expected TMS per TCK period, bit i = period i
  task automatic build_exp(input logic [1:0] op, input int len, output logic [63:0] v, output int n);
    logic q[$];
    q = {};
    if (op == 2'b10) begin
      for (int i = 0; i < 6; i++) q.push_back(i < 5);
    end else begin
      q.push_back(1'b1);
      if (op == 2'b01) q.push_back(1'b1);
      q.push_back(1'b0);
      q.push_back(1'b0);
      for (int i = 0; i < len; i++) q.push_back(i == len - 1);
      q.push_back(1'b1);
      q.push_back(1'b0);
    end
    v = '0;
    foreach (q[i]) v[i] = q[i];
    n = q.size();
  endtask

  task automatic pack_log(output logic [63:0] v, output int n);
    v = '0;
    for (int i = 0; i < tms_log.size() && i < 64; i++) v[i] = tms_log[i];
    n = tms_log.size();
  endtask

  function automatic logic [31:0] bypass_cap(input int len, input logic [31:0] data);
    logic [63:0] m64;
    m64 = (64'd1 << len) - 64'd1;
    return 32'(({32'd0, data} << 1) & m64);
  endfunction

  // Issue one command on the main DUT and observe until done (bounded)
  task automatic run_main(input logic [1:0] op, input int len, input logic [31:0] data,
                          input int extra_start_k, output int done_k, output logic err_at_done,
                          output logic busy_at0, output logic busy_at_done);
    tms_log.delete();
    cmd_op = op; shift_len = LEN_W'(len); shift_data = data; start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    cmd_op = 2'($urandom); shift_len = LEN_W'($urandom); shift_data = $urandom;
    busy_at0 = busy2; done_k = -1; err_at_done = 1'b0; busy_at_done = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      start2 = (k == extra_start_k);
      if (done2 === 1'b1) begin
        done_k = k; err_at_done = err2; busy_at_done = busy2;
        break;
      end
      cyc();
    end
    start2 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int k, seen_done, seen_tdi, an;
    logic [63:0] av;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #1;
    n_tests++;
    if ({tck2, tms2, tdi2, busy2, done2, err2} !== 6'b010100) begin
      n_fail++; $display("FAIL reset_pins got=%b want=010100", {tck2, tms2, tdi2, busy2, done2, err2});
    end
    n_tests++;
    if (cap2 !== '0) begin n_fail++; $display("FAIL reset_cap got=%h want=0", cap2); end
    repeat (3) cyc();
    tms_log.delete();
    nRST = 1'b1;
    seen_done = 0; seen_tdi = 0; k = 0;
    while (busy2 !== 1'b0 && k < 500) begin
      cyc(); k++;
      if (done2 === 1'b1) seen_done++;
      if (tdi2 === 1'b1) seen_tdi++;
    end
    cyc();
    if (done2 === 1'b1) seen_done++;
    n_tests++;
    if (busy2 !== 1'b0) begin n_fail++; $display("FAIL tlr_busy_fall got=%b want=0 after %0d cycles", busy2, k); end
    n_tests++;
    if (seen_done != 0) begin n_fail++; $display("FAIL tlr_no_done got=%0d pulses want=0", seen_done); end
    n_tests++;
    if (seen_tdi != 0) begin n_fail++; $display("FAIL tlr_tdi_low got=%0d high cycles want=0", seen_tdi); end
    pack_log(av, an);
    n_tests++;
    if (an != 6 || av[5:0] !== 6'b011111) begin
      n_fail++; $display("FAIL tlr_tms got=%0d periods %b want=6 periods 011111", an, av[5:0]);
    end
    n_tests++;
    if (tap_st !== T_RTI) begin n_fail++; $display("FAIL tlr_tap_state got=%0d want=%0d", tap_st, T_RTI); end
    k = 0;
    while ((busy1 !== 1'b0 || busy3 !== 1'b0) && k < 500) begin cyc(); k++; end
    n_tests++;
    if ({busy1, busy3} !== 2'b00) begin n_fail++; $display("FAIL tlr_div_busy got=%b want=00", {busy1, busy3}); end
  endtask

  task automatic test_ir_scan(input logic [4:0] data, input logic fixed);
    int dk, en, an;
    logic e, b0, bd;
    logic [63:0] ev, av;
    run_main(2'b01, 5, {27'd0, data}, -1, dk, e, b0, bd);
    build_exp(2'b01, 5, ev, en);
    pack_log(av, an);
    n_tests++;
    if (dk != 45) begin n_fail++; $display("FAIL ir_done_time got=%0d want=45", dk); end
    n_tests++;
    if ({e, b0, bd} !== 3'b010) begin n_fail++; $display("FAIL ir_flags err/busy0/busydone got=%b want=010", {e, b0, bd}); end
    n_tests++;
    if (cap2 !== 32'h1) begin n_fail++; $display("FAIL ir_capture got=%h want=00000001", cap2); end
    n_tests++;
    if (ir_reg !== data) begin n_fail++; $display("FAIL ir_update got=%h want=%h", ir_reg, data); end
    if (fixed) begin
      n_tests++;
      if (an != en || av !== ev) begin
        n_fail++; $display("FAIL ir_tms got=%0d/%h want=%0d/%h", an, av, en, ev);
      end
      cyc();
      n_tests++;
      if (done2 !== 1'b0) begin n_fail++; $display("FAIL ir_done_pulse got=%b want=0", done2); end
    end
  endtask

  task automatic test_dr_scan(input int len, input logic [31:0] data, input int extra_k);
    int dk, en, an;
    logic e, b0, bd;
    logic [63:0] ev, av;
    run_main(2'b00, len, data, extra_k, dk, e, b0, bd);
    build_exp(2'b00, len, ev, en);
    pack_log(av, an);
    n_tests++;
    if (cap2 !== bypass_cap(len, data)) begin
      n_fail++; $display("FAIL dr_capture len=%0d got=%h want=%h", len, cap2, bypass_cap(len, data));
    end
    n_tests++;
    if (dk != 1 + 4 * (len + 5)) begin n_fail++; $display("FAIL dr_done_time len=%0d got=%0d want=%0d", len, dk, 1 + 4 * (len + 5)); end
    n_tests++;
    if ({e, b0, bd} !== 3'b010) begin n_fail++; $display("FAIL dr_flags err/busy0/busydone got=%b want=010", {e, b0, bd}); end
    n_tests++;
    if (an != en || av !== ev) begin n_fail++; $display("FAIL dr_tms len=%0d got=%0d/%h want=%0d/%h", len, an, av, en, ev); end
    n_tests++;
    if (tap_st !== T_RTI) begin n_fail++; $display("FAIL dr_tap_state got=%0d want=%0d", tap_st, T_RTI); end
  endtask

  task automatic test_random_scans();
    for (int i = 0; i < 8; i++) test_dr_scan($urandom_range(1, 32), $urandom, -1);
    for (int i = 0; i < 3; i++) test_ir_scan(5'($urandom), 1'b0);
  endtask

  task automatic test_tap_reset();
    int dk, an;
    logic e, b0, bd;
    logic [63:0] av;
    logic [31:0] d;
    d = $urandom;
    test_dr_scan(16, d, -1);
    run_main(2'b10, 1, 32'h0, -1, dk, e, b0, bd);
    pack_log(av, an);
    n_tests++;
    if (dk != 25) begin n_fail++; $display("FAIL rst_done_time got=%0d want=25", dk); end
    n_tests++;
    if (cap2 !== bypass_cap(16, d)) begin n_fail++; $display("FAIL rst_cap_held got=%h want=%h", cap2, bypass_cap(16, d)); end
    n_tests++;
    if (an != 6 || av[5:0] !== 6'b011111 || e !== 1'b0) begin
      n_fail++; $display("FAIL rst_tms got=%0d/%b err=%b want=6/011111 err=0", an, av[5:0], e);
    end
    n_tests++;
    if (tap_st !== T_RTI) begin n_fail++; $display("FAIL rst_tap_state got=%0d want=%0d", tap_st, T_RTI); end
  endtask

  task automatic test_reject();
    logic [1:0] ops[3];
    int lens[3];
    int tck_hi, busy_hi, done_hi;
    ops[0] = 2'b00; lens[0] = 0;
    ops[1] = 2'b01; lens[1] = 33;
    ops[2] = 2'b11; lens[2] = 5;
    test_dr_scan(8, 32'hA5, -1);
    for (int i = 0; i < 3; i++) begin
      cmd_op = ops[i]; shift_len = LEN_W'(lens[i]); shift_data = $urandom; start2 = 1'b1;
      cyc();
      start2 = 1'b0;
      n_tests++;
      if ({done2, err2, busy2} !== 3'b110) begin
        n_fail++; $display("FAIL reject_flags case=%0d done/err/busy got=%b want=110", i, {done2, err2, busy2});
      end
      tck_hi = 0; busy_hi = 0; done_hi = 0;
      for (int k = 0; k < 8; k++) begin
        cyc();
        if (tck2 !== 1'b0) tck_hi++;
        if (busy2 !== 1'b0) busy_hi++;
        if (done2 !== 1'b0) done_hi++;
      end
      n_tests++;
      if (tck_hi != 0 || busy_hi != 0 || done_hi != 0) begin
        n_fail++; $display("FAIL reject_quiet case=%0d tck/busy/done cycles got=%0d/%0d/%0d want=0/0/0", i, tck_hi, busy_hi, done_hi);
      end
      n_tests++;
      if (cap2 !== 32'h4A) begin n_fail++; $display("FAIL reject_cap case=%0d got=%h want=0000004a", i, cap2); end
    end
  endtask

  task automatic test_back_to_back();
    test_dr_scan(20, $urandom, 30);
    test_ir_scan(5'($urandom), 1'b0);
    test_dr_scan(32, 32'hDEADBEEF, -1);
    n_tests++;
    if (cap2 !== 32'hBD5B7DDE) begin n_fail++; $display("FAIL dr32_bypass got=%h want=bd5b7dde", cap2); end
  endtask

  task automatic test_clk_div();
    int c, done_k, tdi_bad, rises;
    logic prev_tck, d, e, t, m, ti;
    logic [31:0] cp;
    logic [7:0] tms_seen;
    for (int w = 0; w < 2; w++) begin
      c = (w == 0) ? 1 : 3;
      done_k = -1; tdi_bad = 0; rises = 0; prev_tck = 1'b0; tms_seen = '0; e = 1'b0; cp = '0;
      cmd_op = 2'b00; shift_len = LEN_W'(1); shift_data = 32'h1;
      if (w == 0) start1 = 1'b1; else start3 = 1'b1;
      cyc();
      start1 = 1'b0; start3 = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if (w == 0) begin d = done1; e = err1; t = tck1; m = tms1; ti = tdi1; cp = cap1; end
        else begin d = done3; e = err3; t = tck3; m = tms3; ti = tdi3; cp = cap3; end
        if (t === 1'b1 && prev_tck === 1'b0) begin
          if (rises < 8) tms_seen[rises] = m;
          rises++;
        end
        prev_tck = t;
        if (ti !== ((k >= 6 * c) && (k < 8 * c))) tdi_bad++;
        if (d === 1'b1) begin done_k = k; break; end
        cyc();
      end
      n_tests++;
      if (done_k != 1 + 12 * c) begin n_fail++; $display("FAIL div%0d_done_time got=%0d want=%0d", c, done_k, 1 + 12 * c); end
      n_tests++;
      if (tdi_bad != 0) begin n_fail++; $display("FAIL div%0d_tdi_window got=%0d bad cycles want=0", c, tdi_bad); end
      n_tests++;
      if (rises != 6 || tms_seen[5:0] !== 6'b011001) begin
        n_fail++; $display("FAIL div%0d_tms got=%0d/%b want=6/011001", c, rises, tms_seen[5:0]);
      end
      n_tests++;
      if (e !== 1'b0 || cp !== '0) begin n_fail++; $display("FAIL div%0d_err_cap got=%b/%h want=0/0", c, e, cp); end
    end
  endtask

  task automatic test_reset_mid();
    int k, an;
    logic [63:0] av;
    cmd_op = 2'b00; shift_len = LEN_W'(32); shift_data = $urandom; start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    repeat (49) cyc();
    n_tests++;
    if (tap_st !== T_SH_DR || busy2 !== 1'b1) begin
      n_fail++; $display("FAIL mid_in_shift tap=%0d busy=%b want=%0d/1", tap_st, busy2, T_SH_DR);
    end
    #2 nRST = 1'b0;
    #1;
    n_tests++;
    if ({tck2, tms2, tdi2, busy2, done2, err2} !== 6'b010100 || cap2 !== '0) begin
      n_fail++; $display("FAIL mid_reset_pins got=%b/%h want=010100/0", {tck2, tms2, tdi2, busy2, done2, err2}, cap2);
    end
    tms_log.delete();
    repeat (2) cyc();
    nRST = 1'b1;
    k = 0;
    while (busy2 !== 1'b0 && k < 500) begin cyc(); k++; end
    pack_log(av, an);
    n_tests++;
    if (busy2 !== 1'b0 || an != 6 || av[5:0] !== 6'b011111 || tap_st !== T_RTI) begin
      n_fail++; $display("FAIL mid_tlr busy=%b tms=%0d/%b tap=%0d want=0 6/011111 %0d", busy2, an, av[5:0], tap_st, T_RTI);
    end
    k = 0;
    while ((busy1 !== 1'b0 || busy3 !== 1'b0) && k < 500) begin cyc(); k++; end
    test_ir_scan(5'($urandom), 1'b1);
  endtask

  initial begin
    test_reset();
    test_ir_scan(5'h02, 1'b1);
    test_dr_scan(32, 32'hDEADBEEF, -1);
    test_random_scans();
    test_tap_reset();
    test_reject();
    test_back_to_back();
    test_clk_div();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
